// File: rtl/wishbone_rr_arbiter.sv
// Wishbone bus arbiter: grants one of NUM_MASTERS masters the shared slave bus,
// using round-robin or fixed-priority selection, with per-owner bus lock and grant parking.
module wishbone_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MODE        = 0,
    parameter int GNT_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_MASTERS-1:0] CYC_I,
    input  logic [NUM_MASTERS-1:0] LOCK_I,
    output logic [GNT_W-1:0]       GNT,
    output logic [NUM_MASTERS-1:0] GNT_OH,
    output logic                   GNT_VALID,
    output logic                   CYC
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } arbState_e;

    arbState_e        state_q, state_d;
    logic [GNT_W-1:0] gnt_q, gnt_d;
    logic [GNT_W-1:0] winnerIdx;
    logic             winnerFound;
    logic [GNT_W:0]   rotSum;
    logic [GNT_W-1:0] rotIdx;
    logic             ownerCyc;
    logic             ownerLock;

    assign ownerCyc  = CYC_I[gnt_q];
    assign ownerLock = LOCK_I[gnt_q];

    // The one-bit-wider sum lets gnt_q + k wrap with a single subtraction, so the
    // index never leaves 0..NUM_MASTERS-1 even when NUM_MASTERS is not a power of two.
    always_comb begin
        winnerIdx   = gnt_q;
        winnerFound = 1'b0;
        rotSum      = '0;
        rotIdx      = '0;
        if (MODE == 1) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!winnerFound && CYC_I[i]) begin
                    winnerIdx   = GNT_W'(i);
                    winnerFound = 1'b1;
                end
            end
        end else begin
            for (int k = 1; k <= NUM_MASTERS; k++) begin
                rotSum = {1'b0, gnt_q} + (GNT_W+1)'(k);
                if (rotSum >= (GNT_W+1)'(NUM_MASTERS)) begin
                    rotSum = rotSum - (GNT_W+1)'(NUM_MASTERS);
                end
                rotIdx = rotSum[GNT_W-1:0];
                if (!winnerFound && CYC_I[rotIdx]) begin
                    winnerIdx   = rotIdx;
                    winnerFound = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (|CYC_I) begin
                    gnt_d   = winnerIdx;
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED: begin
                // No preemption: only the owner's own CYC/LOCK decide when to let go.
                if (!ownerCyc && !ownerLock) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        GNT_OH        = '0;
        GNT_OH[gnt_q] = 1'b1;
    end

    assign GNT       = gnt_q;
    assign GNT_VALID = (state_q == S_GRANTED);
    assign CYC       = !RST && (state_q == S_GRANTED) && ownerCyc;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: three instances (4-master round-robin,
// 4-master fixed priority, 3-master round-robin) driven from one shared request stream.
module tb_wishbone_rr_arbiter;

    logic       clk;
    logic       rstIn;
    logic [3:0] cycIn;
    logic [3:0] lockIn;

    logic [1:0] gnt0, gnt1, gnt2;
    logic [3:0] oh0, oh1;
    logic [2:0] oh2;
    logic       valid0, valid1, valid2;
    logic       cyc0, cyc1, cyc2;

    int errorCount = 0;
    int checkCount = 0;

    typedef struct {
        int dut;
        int gnt;
        bit valid;
    } expT;

    expT expQ[$];

    int         nM[3]    = '{4, 4, 3};
    int         modeM[3] = '{0, 1, 0};
    logic [3:0] maskM[3] = '{4'hF, 4'hF, 4'h7};
    int         mState[3];
    int         mGnt[3];

    logic [31:0] obsGnt[3];
    logic [31:0] obsOh[3];
    logic [31:0] obsValid[3];
    logic [31:0] obsCyc[3];

    wishbone_rr_arbiter #(.NUM_MASTERS(4), .MODE(0)) dutRr4 (
        .CLK(clk), .RST(rstIn), .CYC_I(cycIn), .LOCK_I(lockIn),
        .GNT(gnt0), .GNT_OH(oh0), .GNT_VALID(valid0), .CYC(cyc0)
    );

    wishbone_rr_arbiter #(.NUM_MASTERS(4), .MODE(1)) dutFp4 (
        .CLK(clk), .RST(rstIn), .CYC_I(cycIn), .LOCK_I(lockIn),
        .GNT(gnt1), .GNT_OH(oh1), .GNT_VALID(valid1), .CYC(cyc1)
    );

    wishbone_rr_arbiter #(.NUM_MASTERS(3), .MODE(0)) dutRr3 (
        .CLK(clk), .RST(rstIn), .CYC_I(cycIn[2:0]), .LOCK_I(lockIn[2:0]),
        .GNT(gnt2), .GNT_OH(oh2), .GNT_VALID(valid2), .CYC(cyc2)
    );

    assign obsGnt[0]   = 32'(gnt0);
    assign obsGnt[1]   = 32'(gnt1);
    assign obsGnt[2]   = 32'(gnt2);
    assign obsOh[0]    = 32'(oh0);
    assign obsOh[1]    = 32'(oh1);
    assign obsOh[2]    = 32'(oh2);
    assign obsValid[0] = 32'(valid0);
    assign obsValid[1] = 32'(valid1);
    assign obsValid[2] = 32'(valid2);
    assign obsCyc[0]   = 32'(cyc0);
    assign obsCyc[1]   = 32'(cyc1);
    assign obsCyc[2]   = 32'(cyc2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    function automatic int pickWinner(input int n, input int mode, input int gnt, input logic [3:0] req);
        if (mode == 1) begin
            for (int i = 0; i < n; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) if (req[(gnt + k) % n]) return (gnt + k) % n;
        end
        return gnt;
    endfunction

    // Drive one cycle of inputs, check combinational CYC immediately, queue the
    // post-edge expectation from the reference model, then retire it after the edge.
    task automatic applyStimulus(input logic [3:0] cyc, input logic [3:0] lock, input logic rst);
        logic [3:0] req;
        logic       expCyc[3];
        expT        e;
        @(negedge clk);
        rstIn  = rst;
        cycIn  = cyc;
        lockIn = lock;
        for (int d = 0; d < 3; d++) begin
            req       = cyc & maskM[d];
            expCyc[d] = !rst && (mState[d] == 1) && req[mGnt[d]];
            if (rst) begin
                mState[d] = 0;
                mGnt[d]   = 0;
            end else if (mState[d] == 0) begin
                if (req != 4'h0) begin
                    mGnt[d]   = pickWinner(nM[d], modeM[d], mGnt[d], req);
                    mState[d] = 1;
                end
            end else if (!req[mGnt[d]] && !lock[mGnt[d]]) begin
                mState[d] = 0;
            end
            e.dut   = d;
            e.gnt   = mGnt[d];
            e.valid = (mState[d] == 1);
            expQ.push_back(e);
        end
        #1;
        for (int d = 0; d < 3; d++) checkOutput($sformatf("dut%0d.cyc", d), obsCyc[d], 32'(expCyc[d]));
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardEmpty", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("dut%0d.gnt", e.dut), obsGnt[e.dut], 32'(e.gnt));
                checkOutput($sformatf("dut%0d.valid", e.dut), obsValid[e.dut], 32'(e.valid));
                checkOutput($sformatf("dut%0d.gntOh", e.dut), obsOh[e.dut], 32'(1) << e.gnt);
            end
        end
    endtask

    initial begin
        int   rrOrder[5] = '{1, 2, 3, 0, 1};
        logic sawGnt3;
        logic [3:0] rCyc, rLock;
        rstIn  = 1'b1;
        cycIn  = 4'h0;
        lockIn = 4'h0;
        for (int d = 0; d < 3; d++) begin
            mState[d] = 0;
            mGnt[d]   = 0;
        end

        // Reset with every master requesting, then the first grant.
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        checkOutput("resetGnt", obsGnt[0], 32'd0);
        checkOutput("resetOh", obsOh[0], 32'b0001);
        checkOutput("resetCyc", obsCyc[0], 32'd0);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("firstGntRr", obsGnt[0], 32'd1);
        checkOutput("firstGntFp", obsGnt[1], 32'd0);
        checkOutput("firstGntRr3", obsGnt[2], 32'd1);

        // Round-robin fairness: each owner keeps the bus 3 cycles then drops CYC for one.
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rrOrder%0d", k), obsGnt[0], 32'(rrOrder[k]));
            checkOutput($sformatf("rrValid%0d", k), obsValid[0], 32'd1);
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            applyStimulus(4'b1111 & ~(4'b0001 << rrOrder[k]), 4'b0000, 1'b0);
            checkOutput($sformatf("rrDead%0d", k), obsValid[0], 32'd0);
            applyStimulus(4'b1111, 4'b0000, 1'b0);
        end

        // Fixed priority: master 1 beats master 3 whenever it is requesting.
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        checkOutput("fpGnt1", obsGnt[1], 32'd1);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("fpIdle", obsValid[1], 32'd0);
        applyStimulus(4'b1010, 4'b0000, 1'b0);
        checkOutput("fpRegnt1", obsGnt[1], 32'd1);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("fpGnt3", obsGnt[1], 32'd3);

        // Lock: master 2 holds the bus through a CYC gap while master 0 waits.
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0100, 4'b0100, 1'b0);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(4'b0001, 4'b0100, 1'b0);
            checkOutput($sformatf("lockGnt%0d", g), obsGnt[0], 32'd2);
            checkOutput($sformatf("lockValid%0d", g), obsValid[0], 32'd1);
            checkOutput($sformatf("lockCyc%0d", g), obsCyc[0], 32'd0);
        end
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("lockRelease", obsValid[0], 32'd0);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("lockNext", obsGnt[0], 32'd0);

        // Three masters: owner 2 releasing with only master 0 requesting wraps to 0.
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        checkOutput("wrapOwner", obsGnt[2], 32'd2);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        checkOutput("wrapGnt0", obsGnt[2], 32'd0);

        sawGnt3 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            rCyc  = 4'($urandom);
            rLock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            applyStimulus(rCyc, rLock, ($urandom_range(0, 99) == 0));
            if (gnt2 > 2'd2) sawGnt3 = 1'b1;
        end
        checkOutput("gnt3Range", 32'(sawGnt3), 32'd0);

        // Reset while master 3 is locked and active.
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        checkOutput("midOwner", obsGnt[0], 32'd3);
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        checkOutput("midRstCyc", obsCyc[0], 32'd0);
        checkOutput("midRstGnt", obsGnt[0], 32'd0);
        checkOutput("midRstValid", obsValid[0], 32'd0);
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        checkOutput("midRegnt", obsGnt[0], 32'd3);
        checkOutput("midRegntValid", obsValid[0], 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
